// File: rtl/dsc_seq_pkg.sv
// Shared types for the dsc_serial_mul sequencer: FSM state encoding and
// default-configuration operand vector type.
package dsc_seq_pkg;

  localparam int SEQ_DATA_WIDTH = 8;
  localparam int SEQ_NUM_INPUTS = 4;
  localparam int SEQ_FIFO_DEPTH = 4;
  localparam int FIFO_AW        = $clog2(SEQ_FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    OUT   = 2'd3
  } seq_state_t;

  typedef logic [SEQ_DATA_WIDTH-1:0] operand_vec_t [SEQ_NUM_INPUTS];

endpackage

// File: rtl/dsc_op_fifo.sv
// Operand-vector FIFO: synchronous push/pop, no bypass, async active-high
// reset of pointers and occupancy. Storage is not reset.
module dsc_op_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/dsc_mul_sequencer.sv
// Sequencer around dsc_serial_mul: queues operand vectors, drives the
// multiplier's clear/enable, counts RUN cycles and holds the product on a
// valid/ready result port. Optional macro DSC_MUL_CYCLE_CAP_EN adds a
// cycle cap that cuts an operation short and flags the result truncated.
module dsc_mul_sequencer
  import dsc_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_INPUTS = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             op_valid,
  output logic                             op_ready,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] op_data,
  output logic                             mul_rst,
  output logic                             mul_en,
  output logic [DATA_WIDTH-1:0]            mul_operands [NUM_INPUTS],
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] mul_result,
  input  logic                             mul_done,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic [NUM_INPUTS*DATA_WIDTH-1:0] res_data,
  output logic [CNT_WIDTH-1:0]             res_cycles,
  output logic                             busy
`ifdef DSC_MUL_CYCLE_CAP_EN
  ,
  input  logic [CNT_WIDTH-1:0]             cycle_cap,
  output logic                             res_truncated
`endif
);

  localparam int VW = NUM_INPUTS * DATA_WIDTH;

  seq_state_t                  state;
  seq_state_t                  state_next;
  logic                        pop;
  logic                        capture;
  logic [CNT_WIDTH-1:0]        cnt;
  logic [CNT_WIDTH-1:0]        cnt_inc;
  logic [VW-1:0]               head;
  logic                        full;
  logic                        empty;
  logic [$clog2(FIFO_DEPTH):0] count;
`ifdef DSC_MUL_CYCLE_CAP_EN
  logic                        cap_hit;
`endif

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  dsc_op_fifo #(
    .WIDTH (VW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (op_valid && op_ready),
    .pop   (pop),
    .wdata (op_data),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Count of the RUN cycle in progress, as it will read once this cycle ends.
  assign cnt_inc  = sat_inc(cnt);
  assign op_ready = !full;
  assign busy     = (state != IDLE) || (count != '0);
  assign mul_en   = (state == RUN);
  assign mul_rst  = (state != RUN);

  // Next-state, pop and capture decisions.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    capture    = 1'b0;
`ifdef DSC_MUL_CYCLE_CAP_EN
    cap_hit    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = CLEAR;
        end
      end
      CLEAR: state_next = RUN;
      RUN: begin
        if (mul_done) begin
          capture    = 1'b1;
          state_next = OUT;
        end
`ifdef DSC_MUL_CYCLE_CAP_EN
        else if (cycle_cap != '0 && cnt_inc == cycle_cap) begin
          capture    = 1'b1;
          cap_hit    = 1'b1;
          state_next = OUT;
        end
`endif
      end
      OUT: begin
        if (res_ready) begin
          if (!empty) begin
            pop        = 1'b1;
            state_next = CLEAR;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Operand load on pop and RUN-cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      for (int i = 0; i < NUM_INPUTS; i++) mul_operands[i] <= '0;
    end else if (pop) begin
      cnt <= '0;
      for (int i = 0; i < NUM_INPUTS; i++) mul_operands[i] <= head[i*DATA_WIDTH +: DATA_WIDTH];
    end else if (state == RUN) begin
      cnt <= cnt_inc;
    end
  end

  // Result capture and handshake; a truncated capture has cnt_inc == cycle_cap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_cycles <= '0;
`ifdef DSC_MUL_CYCLE_CAP_EN
      res_truncated <= 1'b0;
`endif
    end else if (capture) begin
      res_valid  <= 1'b1;
      res_data   <= mul_result;
      res_cycles <= cnt_inc;
`ifdef DSC_MUL_CYCLE_CAP_EN
      res_truncated <= cap_hit;
`endif
    end else if (state == OUT && res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dsc_mul_sequencer.sv
// Self-checking bench for dsc_mul_sequencer with a multiplier stub whose
// done latency is chosen per operand vector, and a timeline reference model.
module tb_dsc_mul_sequencer;

  localparam int DW     = 8;
  localparam int NI     = 2;
  localparam int FD     = 4;
  localparam int CW     = 3;
  localparam int VW     = NI * DW;
  localparam int SATMAX = (1 << CW) - 1;

  typedef struct packed {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [31:0] d;
  } vec_t;

  logic          clk;
  logic          rst;
  logic          op_valid;
  logic          op_ready;
  logic [VW-1:0] op_data;
  logic          mul_rst;
  logic          mul_en;
  logic [DW-1:0] mul_operands [NI];
  logic [VW-1:0] mul_result;
  logic          mul_done;
  logic          res_valid;
  logic          res_ready;
  logic [VW-1:0] res_data;
  logic [CW-1:0] res_cycles;
  logic          busy;
  logic [CW-1:0] cycle_cap;
  logic          res_truncated;

  int checks = 0;
  int errors = 0;

  dsc_mul_sequencer #(
    .DATA_WIDTH (DW),
    .NUM_INPUTS (NI),
    .FIFO_DEPTH (FD),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .op_valid     (op_valid),
    .op_ready     (op_ready),
    .op_data      (op_data),
    .mul_rst      (mul_rst),
    .mul_en       (mul_en),
    .mul_operands (mul_operands),
    .mul_result   (mul_result),
    .mul_done     (mul_done),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_cycles   (res_cycles),
    .busy         (busy)
`ifdef DSC_MUL_CYCLE_CAP_EN
    ,
    .cycle_cap     (cycle_cap),
    .res_truncated (res_truncated)
`endif
  );

`ifndef DSC_MUL_CYCLE_CAP_EN
  assign res_truncated = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- multiplier stub ----------------
  int   dly_tab [256];
  int   push_n = 0;
  int   stub_cnt = 0;
  int   stub_idx = 0;
  logic noise = 1'b0;

  assign mul_done   = mul_en ? ((stub_cnt + 1) == dly_tab[stub_idx]) : noise;
  assign mul_result = mul_en ? (16'(mul_operands[0]) * 16'(mul_operands[1])) : 16'hDEAD;

  always @(posedge clk or posedge rst) begin
    noise <= 1'($urandom_range(0, 1));
    if (rst) begin
      stub_cnt <= 0;
      stub_idx <= push_n;
    end else if (mul_en) begin
      stub_cnt <= stub_cnt + 1;
    end else if (stub_cnt != 0) begin
      stub_cnt <= 0;
      stub_idx <= stub_idx + 1;
    end
  end

  // ---------------- reference model ----------------
  // One op's life after its pop edge: 1 CLEAR cycle, m_len RUN cycles, then
  // the result is held until accepted.
  vec_t          m_q[$];
  bit            m_active = 0;
  bit            m_rv = 0;
  int            m_age = 0;
  int            m_len = 0;
  bit            m_tr = 0;
  logic [15:0]   m_prod = 0;
  logic [7:0]    m_ops [NI] = '{0, 0};
  logic [15:0]   m_res_data = 0;
  int            m_res_cyc = 0;
  bit            m_res_tr = 0;
  int            cur_dly = 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_active = 0; m_rv = 0; m_age = 0;
      m_ops = '{0, 0};
      m_res_data = 0; m_res_cyc = 0; m_res_tr = 0;
    end else begin : step
      bit   push_ok;
      bit   pop_now;
      vec_t v;
      push_ok = op_valid && (m_q.size() < FD);
      pop_now = 0;
      if (!m_active) begin
        pop_now = (m_q.size() != 0);
      end else if (m_rv) begin
        if (res_ready) begin
          m_rv = 0; m_active = 0;
          pop_now = (m_q.size() != 0);
        end
      end else begin
        m_age++;
        if (m_age == m_len + 2) begin
          m_rv = 1;
          m_res_data = m_prod;
          m_res_tr = m_tr;
          m_res_cyc = (m_len > SATMAX) ? SATMAX : m_len;
        end
      end
      if (pop_now) begin
        v = m_q.pop_front();
        m_active = 1; m_age = 1;
        m_ops[0] = v.a; m_ops[1] = v.b;
        m_prod = 16'(v.a) * 16'(v.b);
        m_len = int'(v.d); m_tr = 0;
`ifdef DSC_MUL_CYCLE_CAP_EN
        if (cycle_cap != 0 && int'(v.d) > int'(cycle_cap)) begin
          m_len = int'(cycle_cap); m_tr = 1;
        end
`endif
      end
      if (push_ok) begin
        m_q.push_back('{op_data[7:0], op_data[15:8], 32'(cur_dly)});
        dly_tab[push_n] = cur_dly;
        push_n++;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic exp_en;
    exp_en = m_active && !m_rv && (m_age >= 2);
    chk("op_ready",   32'(op_ready),      32'(m_q.size() < FD));
    chk("busy",       32'(busy),          32'(m_active || m_q.size() != 0));
    chk("mul_en",     32'(mul_en),        32'(exp_en));
    chk("mul_rst",    32'(mul_rst),       32'(!exp_en));
    chk("operand0",   32'(mul_operands[0]), 32'(m_ops[0]));
    chk("operand1",   32'(mul_operands[1]), 32'(m_ops[1]));
    chk("res_valid",  32'(res_valid),     32'(m_rv));
    chk("res_data",   32'(res_data),      32'(m_res_data));
    chk("res_cycles", 32'(res_cycles),    32'(m_res_cyc));
`ifdef DSC_MUL_CYCLE_CAP_EN
    chk("res_truncated", 32'(res_truncated), 32'(m_res_tr));
`endif
  end

  // ---------------- stimulus ----------------
  task automatic push(input logic [7:0] a, input logic [7:0] b, input int d);
    int   n;
    logic r;
    n = 0;
    op_valid = 1'b1; op_data = {b, a}; cur_dly = d;
    do begin
      @(negedge clk); r = op_ready;
      @(posedge clk); #1; n++;
    end while (!r && n < 50);
    op_valid = 1'b0;
    chk("push_accept", 32'(r), 1);
  endtask

  task automatic wait_res(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!res_valid && n < 100) begin @(negedge clk); n++; end
    chk({nm, "_valid"}, 32'(res_valid), 1);
  endtask

  task automatic accept();
    @(posedge clk); #1 res_ready = 1'b1;
    @(posedge clk); #1 res_ready = 1'b0;
  endtask

  initial begin
    int   n;
    int   sent;
    logic r;
    rst = 1'b1; op_valid = 1'b0; op_data = '0; res_ready = 1'b0; cycle_cap = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_op_ready", 32'(op_ready), 1);
    chk("rst_mul_rst", 32'(mul_rst), 1);
    chk("rst_mul_en", 32'(mul_en), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    @(posedge clk); #1;

    // Single op: 3*5, done in the 7th RUN cycle.
    push(8'd3, 8'd5, 7);
    wait_res("t1");
    chk("t1_data", 32'(res_data), 15);
    chk("t1_cycles", 32'(res_cycles), 7);
    accept();

    // Five back-to-back vectors with the consumer stalled.
    for (int i = 0; i < 5; i++) push(8'(i + 1), 8'(i + 2), 3 + i);
    @(negedge clk);
    chk("t2_full_ready", 32'(op_ready), 0);
    wait_res("t2");
    repeat (20) @(negedge clk);
    chk("hold_data", 32'(res_data), 2);
    chk("hold_cycles", 32'(res_cycles), 3);
    chk("hold_mul_en", 32'(mul_en), 0);
    @(posedge clk); #1 res_ready = 1'b1;
    n = 0;
    while ((m_active || m_q.size() != 0) && n < 300) begin @(posedge clk); #1; n++; end
    res_ready = 1'b0;
    chk("t2_drained", 32'(m_active || m_q.size() != 0), 0);
    @(negedge clk);
    chk("t2_last_data", 32'(res_data), 30);
    chk("t2_last_cycles", 32'(res_cycles), 7);
    @(posedge clk); #1;

    // Counter saturation: done in the 12th RUN cycle.
    push(8'd2, 8'd9, 12);
    wait_res("sat");
    chk("sat_cycles", 32'(res_cycles), 7);
    chk("sat_data", 32'(res_data), 18);
    accept();

`ifdef DSC_MUL_CYCLE_CAP_EN
    cycle_cap = 3'd4;
    push(8'd4, 8'd4, 10);
    wait_res("cap");
    chk("cap_trunc", 32'(res_truncated), 1);
    chk("cap_cycles", 32'(res_cycles), 4);
    chk("cap_data", 32'(res_data), 16);
    accept();
    cycle_cap = 3'd7;
    push(8'd3, 8'd3, 7);
    wait_res("cap_tie");
    chk("cap_tie_trunc", 32'(res_truncated), 0);
    chk("cap_tie_cycles", 32'(res_cycles), 7);
    accept();
    cycle_cap = '0;
`endif

    // Reset in the 3rd RUN cycle with two vectors queued.
    push(8'd1, 8'd1, 10);
    push(8'd2, 8'd2, 3);
    push(8'd3, 8'd3, 3);
    n = 0;
    do begin @(negedge clk); n++; end while (!mul_en && n < 20);
    chk("abort_run1", 32'(mul_en), 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_mul_en", 32'(mul_en), 0);
    chk("abort_mul_rst", 32'(mul_rst), 1);
    chk("abort_res_valid", 32'(res_valid), 0);
    chk("abort_op_ready", 32'(op_ready), 1);
    chk("abort_busy", 32'(busy), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Randomized traffic.
`ifdef DSC_MUL_CYCLE_CAP_EN
    cycle_cap = 3'd6;
`endif
    sent = 0;
    op_valid = 1'b1; op_data = 16'($urandom); cur_dly = $urandom_range(1, 12);
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk); r = op_ready;
      @(posedge clk); #1;
      if (op_valid && r) sent++;
      op_valid  = (sent < 40) && ($urandom_range(0, 3) != 0);
      op_data   = 16'($urandom);
      cur_dly   = $urandom_range(1, 12);
      res_ready = 1'($urandom_range(0, 1));
      if (sent >= 40 && !m_active && m_q.size() == 0) break;
    end
    op_valid = 1'b0; res_ready = 1'b0;
    chk("rand_drain", 32'(sent == 40 && !m_active && m_q.size() == 0), 1);
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
